pred_table_ctrl: RTL and testbench

Requester-side controller for one single-ported 128-set predictor table SRAM. Each entry holds a 9-bit tag, a 2-bit counter and a 39-bit target. The block turns predictor lookups into SRAM reads with tag compare, and turns training updates into a read-modify-write of the counter and target. It sits between the branch predictor stage logic and the table's SRAM wrapper, driving that wrapper's rreq/wreq ports and consuming its rresp.

---
 rtl/pred_table_ctrl_pkg.sv | 42 ++++
 rtl/pred_ctr_update.sv | 26 ++
 rtl/pred_table_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pred_table_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_table_ctrl_pkg.sv
// Shared types and helpers for the predictor table controllers.
package pred_table_ctrl_pkg;

    localparam int unsigned NumSets = 128;
    localparam int unsigned SetW    = $clog2(NumSets);
    localparam int unsigned TagW    = 9;
    localparam int unsigned TgtW    = 39;
    localparam int unsigned CtrW    = 2;

    localparam logic [CtrW-1:0] CtrMax           = 2'd3;
    localparam logic [CtrW-1:0] CtrMin           = 2'd0;
    // Freshly allocated entries start weakly biased toward the resolved direction.
    localparam logic [CtrW-1:0] CtrAllocTaken    = 2'd2;
    localparam logic [CtrW-1:0] CtrAllocNotTaken = 2'd1;

    typedef struct packed {
        logic [TagW-1:0] tag;
        logic [CtrW-1:0] ctr;
        logic [TgtW-1:0] target;
    } pred_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StChk,
        StWr
    } upd_state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [CtrW-1:0] sat_ctr_update(input logic [CtrW-1:0] ctr,
                                                       input logic            taken);
        logic [CtrW-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CtrMax) res = ctr + 1'b1;
        end else begin
            if (ctr != CtrMin) res = ctr - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pred_ctr_update.sv
// New-entry computation for a training update: train on tag hit, allocate on miss.
module pred_ctr_update
    import pred_table_ctrl_pkg::*;
(
    input  pred_entry_t       old_entry_i,
    input  logic [TagW-1:0]   upd_tag_i,
    input  logic              upd_taken_i,
    input  logic [TgtW-1:0]   upd_target_i,
    output pred_entry_t       new_entry_o
);

    // Merge the resolved outcome into the entry read from the table.
    always_comb begin
        new_entry_o = old_entry_i;
        if (old_entry_i.tag == upd_tag_i) begin
            new_entry_o.ctr = sat_ctr_update(old_entry_i.ctr, upd_taken_i);
            // A not-taken outcome says nothing about the target, so keep the old one.
            if (upd_taken_i) new_entry_o.target = upd_target_i;
        end else begin
            new_entry_o.tag    = upd_tag_i;
            new_entry_o.target = upd_target_i;
            new_entry_o.ctr    = upd_taken_i ? CtrAllocTaken : CtrAllocNotTaken;
        end
    end

endmodule

// File: rtl/pred_table_ctrl.sv
// Requester-side controller for a single-ported predictor table SRAM: lookups with tag
// compare, and training updates as a read-modify-write sequenced by a small FSM.
module pred_table_ctrl
    import pred_table_ctrl_pkg::*;
#(
    parameter  int unsigned NSETS = NumSets,
    parameter  int unsigned TAG_W = TagW,
    parameter  int unsigned TGT_W = TgtW,
    localparam int unsigned SET_W = $clog2(NSETS)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [SET_W-1:0] io_req_bits_setIdx,
    input  logic [TAG_W-1:0] io_req_bits_tag,

    output logic             io_resp_valid,
    output logic             io_resp_bits_hit,
    output logic [1:0]       io_resp_bits_ctr,
    output logic [TGT_W-1:0] io_resp_bits_target,

    input  logic             io_update_valid,
    output logic             io_update_ready,
    input  logic [SET_W-1:0] io_update_bits_setIdx,
    input  logic [TAG_W-1:0] io_update_bits_tag,
    input  logic             io_update_bits_taken,
    input  logic [TGT_W-1:0] io_update_bits_target,

    output logic             io_sram_rreq_valid,
    output logic [SET_W-1:0] io_sram_rreq_bits_setIdx,

    input  logic [TAG_W-1:0] io_sram_rresp_data_0_tag,
    input  logic [1:0]       io_sram_rresp_data_0_ctr,
    input  logic [TGT_W-1:0] io_sram_rresp_data_0_target,

    output logic             io_sram_wreq_valid,
    output logic [SET_W-1:0] io_sram_wreq_bits_setIdx,
    output logic [TAG_W-1:0] io_sram_wreq_bits_data_0_tag,
    output logic [1:0]       io_sram_wreq_bits_data_0_ctr,
    output logic [TGT_W-1:0] io_sram_wreq_bits_data_0_target
);

    upd_state_e state_q, state_d;

    // Latched update request.
    logic [SET_W-1:0] upd_set_q;
    logic [TAG_W-1:0] upd_tag_q;
    logic             upd_taken_q;
    logic [TGT_W-1:0] upd_target_q;

    // Entry computed in CHK and written in WR; also the bypass source.
    pred_entry_t new_entry_d, new_entry_q;
    pred_entry_t rresp_entry;
    pred_entry_t resp_entry;

    // Outstanding lookup.
    logic             lk_valid_q;
    logic [TAG_W-1:0] lk_tag_q;
    logic             lk_bypass_q, lk_bypass_d;

    logic rd_own, wr_own;
    logic req_fire, upd_fire;

    // Handshakes are ignored while reset is held so nothing is latched into a dead state.
    assign req_fire = io_req_valid & io_req_ready & ~reset;
    assign upd_fire = io_update_valid & io_update_ready & ~reset;

    // Update FSM next state and handshake readiness.
    always_comb begin
        state_d         = state_q;
        io_update_ready = 1'b0;
        io_req_ready    = 1'b0;
        rd_own          = 1'b0;
        wr_own          = 1'b0;
        unique case (state_q)
            StIdle: begin
                io_update_ready = 1'b1;
                io_req_ready    = 1'b1;
                if (upd_fire) state_d = StRd;
            end
            StRd: begin
                rd_own  = 1'b1;
                state_d = StChk;
            end
            StChk: begin
                // The port is free here: the update's read data is already on rresp.
                io_req_ready = 1'b1;
                state_d      = StWr;
            end
            StWr: begin
                wr_own  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and valid flags with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            lk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lk_valid_q <= req_fire;
        end
    end

    // Datapath registers; contents only matter while the matching valid/state is live.
    always_ff @(posedge clock) begin
        if (upd_fire) begin
            upd_set_q    <= io_update_bits_setIdx;
            upd_tag_q    <= io_update_bits_tag;
            upd_taken_q  <= io_update_bits_taken;
            upd_target_q <= io_update_bits_target;
        end
        if (state_q == StChk) new_entry_q <= new_entry_d;
        if (req_fire) begin
            lk_tag_q    <= io_req_bits_tag;
            lk_bypass_q <= lk_bypass_d;
        end
    end

    // A lookup racing the write of the same set must see the entry being written.
    always_comb begin
        lk_bypass_d = (state_q == StChk) && (io_req_bits_setIdx == upd_set_q);
    end

    assign rresp_entry = '{tag:    io_sram_rresp_data_0_tag,
                           ctr:    io_sram_rresp_data_0_ctr,
                           target: io_sram_rresp_data_0_target};

    pred_ctr_update u_ctr_update (
        .old_entry_i  (rresp_entry),
        .upd_tag_i    (upd_tag_q),
        .upd_taken_i  (upd_taken_q),
        .upd_target_i (upd_target_q),
        .new_entry_o  (new_entry_d)
    );

    // SRAM request muxing; the FSM owns the port in RD and WR, lookups otherwise.
    always_comb begin
        io_sram_rreq_valid       = (rd_own | req_fire) & ~reset;
        io_sram_rreq_bits_setIdx = rd_own ? upd_set_q : io_req_bits_setIdx;

        io_sram_wreq_valid              = wr_own & ~reset;
        io_sram_wreq_bits_setIdx        = upd_set_q;
        io_sram_wreq_bits_data_0_tag    = new_entry_q.tag;
        io_sram_wreq_bits_data_0_ctr    = new_entry_q.ctr;
        io_sram_wreq_bits_data_0_target = new_entry_q.target;
    end

    // Lookup response from SRAM data or the bypassed new entry.
    always_comb begin
        resp_entry          = lk_bypass_q ? new_entry_q : rresp_entry;
        io_resp_valid       = lk_valid_q;
        io_resp_bits_hit    = (resp_entry.tag == lk_tag_q);
        io_resp_bits_ctr    = resp_entry.ctr;
        io_resp_bits_target = resp_entry.target;
    end

endmodule

// File: tb/tb_pred_table_ctrl.sv
// Self-checking bench for pred_table_ctrl with an SRAM model and a reference table.
module tb_pred_table_ctrl;

    typedef struct packed {
        logic [8:0]  tag;
        logic [1:0]  ctr;
        logic [38:0] tgt;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [6:0]  io_req_bits_setIdx = '0;
    logic [8:0]  io_req_bits_tag = '0;
    logic        io_resp_valid;
    logic        io_resp_bits_hit;
    logic [1:0]  io_resp_bits_ctr;
    logic [38:0] io_resp_bits_target;
    logic        io_update_valid = 1'b0;
    logic        io_update_ready;
    logic [6:0]  io_update_bits_setIdx = '0;
    logic [8:0]  io_update_bits_tag = '0;
    logic        io_update_bits_taken = 1'b0;
    logic [38:0] io_update_bits_target = '0;
    logic        io_sram_rreq_valid;
    logic [6:0]  io_sram_rreq_bits_setIdx;
    logic [8:0]  rresp_tag = '0;
    logic [1:0]  rresp_ctr = '0;
    logic [38:0] rresp_tgt = '0;
    logic        io_sram_wreq_valid;
    logic [6:0]  io_sram_wreq_bits_setIdx;
    logic [8:0]  wreq_tag;
    logic [1:0]  wreq_ctr;
    logic [38:0] wreq_tgt;

    int checks = 0;
    int failures = 0;
    int collisions = 0;

    ent_t mem [128];
    ent_t ref_tbl [128];

    always #5 clock = ~clock;

    pred_table_ctrl dut (
        .clock                           (clock),
        .reset                           (reset),
        .io_req_valid                    (io_req_valid),
        .io_req_ready                    (io_req_ready),
        .io_req_bits_setIdx              (io_req_bits_setIdx),
        .io_req_bits_tag                 (io_req_bits_tag),
        .io_resp_valid                   (io_resp_valid),
        .io_resp_bits_hit                (io_resp_bits_hit),
        .io_resp_bits_ctr                (io_resp_bits_ctr),
        .io_resp_bits_target             (io_resp_bits_target),
        .io_update_valid                 (io_update_valid),
        .io_update_ready                 (io_update_ready),
        .io_update_bits_setIdx           (io_update_bits_setIdx),
        .io_update_bits_tag              (io_update_bits_tag),
        .io_update_bits_taken            (io_update_bits_taken),
        .io_update_bits_target           (io_update_bits_target),
        .io_sram_rreq_valid              (io_sram_rreq_valid),
        .io_sram_rreq_bits_setIdx        (io_sram_rreq_bits_setIdx),
        .io_sram_rresp_data_0_tag        (rresp_tag),
        .io_sram_rresp_data_0_ctr        (rresp_ctr),
        .io_sram_rresp_data_0_target     (rresp_tgt),
        .io_sram_wreq_valid              (io_sram_wreq_valid),
        .io_sram_wreq_bits_setIdx        (io_sram_wreq_bits_setIdx),
        .io_sram_wreq_bits_data_0_tag    (wreq_tag),
        .io_sram_wreq_bits_data_0_ctr    (wreq_ctr),
        .io_sram_wreq_bits_data_0_target (wreq_tgt)
    );

    // SRAM model: read data one cycle after rreq; count port collisions.
    always @(posedge clock) begin
        if (io_sram_rreq_valid) begin
            rresp_tag <= mem[io_sram_rreq_bits_setIdx].tag;
            rresp_ctr <= mem[io_sram_rreq_bits_setIdx].ctr;
            rresp_tgt <= mem[io_sram_rreq_bits_setIdx].tgt;
        end
        if (io_sram_wreq_valid) mem[io_sram_wreq_bits_setIdx] <= '{wreq_tag, wreq_ctr, wreq_tgt};
        if (io_sram_rreq_valid && io_sram_wreq_valid) collisions <= collisions + 1;
    end

    // Training rule: hit moves the counter by one within 0..3, miss allocates.
    function automatic ent_t model_next(ent_t old, logic [8:0] tag, logic taken,
                                        logic [38:0] tgt);
        ent_t n;
        int   c;
        if (old.tag == tag) begin
            c = int'(old.ctr);
            if (taken) c = (c + 1 > 3) ? 3 : c + 1;
            else       c = (c - 1 < 0) ? 0 : c - 1;
            n.tag = old.tag;
            n.ctr = 2'(c);
            n.tgt = taken ? tgt : old.tgt;
        end else begin
            n.tag = tag;
            n.ctr = taken ? 2'd2 : 2'd1;
            n.tgt = tgt;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (io_update_ready !== 1'b1) begin failures++;
            $display("FAIL rst_update_ready got=%0h exp=1", io_update_ready); end
        checks++; if (io_req_ready !== 1'b1) begin failures++;
            $display("FAIL rst_req_ready got=%0h exp=1", io_req_ready); end
        checks++; if (io_resp_valid !== 1'b0) begin failures++;
            $display("FAIL rst_resp_valid got=%0h exp=0", io_resp_valid); end
        checks++; if (io_sram_rreq_valid !== 1'b0 || io_sram_wreq_valid !== 1'b0) begin
            failures++; $display("FAIL rst_sram_valid got=%0h/%0h exp=0/0",
                                 io_sram_rreq_valid, io_sram_wreq_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic do_lookup(input logic [6:0] set, input logic [8:0] tag);
        ent_t e;
        io_req_valid = 1'b1; io_req_bits_setIdx = set; io_req_bits_tag = tag;
        #1;
        checks++; if (io_req_ready !== 1'b1 || io_sram_rreq_valid !== 1'b1 ||
                      io_sram_rreq_bits_setIdx !== set) begin failures++;
            $display("FAIL lk_rreq got=%0h/%0h/%0h exp=1/1/%0h", io_req_ready,
                     io_sram_rreq_valid, io_sram_rreq_bits_setIdx, set); end
        tick();
        io_req_valid = 1'b0; io_req_bits_setIdx = 7'($urandom);
        #1;
        e = ref_tbl[set];
        checks++; if (io_resp_valid !== 1'b1) begin failures++;
            $display("FAIL lk_resp_valid got=%0h exp=1", io_resp_valid); end
        checks++; if (io_resp_bits_hit !== (e.tag == tag) || io_resp_bits_ctr !== e.ctr ||
                      io_resp_bits_target !== e.tgt) begin failures++;
            $display("FAIL lk_resp set=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", set,
                     io_resp_bits_hit, io_resp_bits_ctr, io_resp_bits_target,
                     (e.tag == tag), e.ctr, e.tgt); end
        tick();
    endtask

    // Full update sequence; optionally a lookup is presented in CHK.
    task automatic do_update(input logic [6:0] set, input logic [8:0] tag, input logic taken,
                             input logic [38:0] tgt, input logic lk_en,
                             input logic [6:0] lk_set, input logic [8:0] lk_tag);
        ent_t nw, le;
        io_update_valid = 1'b1; io_update_bits_setIdx = set; io_update_bits_tag = tag;
        io_update_bits_taken = taken; io_update_bits_target = tgt;
        #1;
        checks++; if (io_update_ready !== 1'b1) begin failures++;
            $display("FAIL upd_idle_ready got=%0h exp=1", io_update_ready); end
        tick();
        io_update_valid = 1'b0; io_update_bits_setIdx = 7'($urandom);
        io_update_bits_tag = 9'($urandom);
        #1;
        checks++; if (io_sram_rreq_valid !== 1'b1 || io_sram_rreq_bits_setIdx !== set) begin
            failures++; $display("FAIL upd_rd_rreq got=%0h/%0h exp=1/%0h",
                                 io_sram_rreq_valid, io_sram_rreq_bits_setIdx, set); end
        checks++; if (io_update_ready !== 1'b0 || io_req_ready !== 1'b0 ||
                      io_sram_wreq_valid !== 1'b0) begin failures++;
            $display("FAIL upd_rd_ctl got=%0h/%0h/%0h exp=0/0/0", io_update_ready,
                     io_req_ready, io_sram_wreq_valid); end
        nw = model_next(ref_tbl[set], tag, taken, tgt);
        tick();
        if (lk_en) begin
            io_req_valid = 1'b1; io_req_bits_setIdx = lk_set; io_req_bits_tag = lk_tag;
        end
        #1;
        checks++; if (io_update_ready !== 1'b0 || io_req_ready !== 1'b1 ||
                      io_sram_wreq_valid !== 1'b0 || io_sram_rreq_valid !== lk_en) begin
            failures++; $display("FAIL upd_chk_ctl got=%0h/%0h/%0h/%0h exp=0/1/0/%0h",
                io_update_ready, io_req_ready, io_sram_wreq_valid, io_sram_rreq_valid, lk_en);
        end
        tick();
        io_req_valid = 1'b0;
        #1;
        checks++; if (io_sram_wreq_valid !== 1'b1 || io_sram_wreq_bits_setIdx !== set ||
                      io_sram_rreq_valid !== 1'b0 || io_req_ready !== 1'b0) begin
            failures++; $display("FAIL upd_wr_ctl got=%0h/%0h/%0h/%0h exp=1/%0h/0/0",
                io_sram_wreq_valid, io_sram_wreq_bits_setIdx, io_sram_rreq_valid,
                io_req_ready, set); end
        checks++; if (wreq_tag !== nw.tag || wreq_ctr !== nw.ctr || wreq_tgt !== nw.tgt) begin
            failures++; $display("FAIL upd_wr_data set=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                set, wreq_tag, wreq_ctr, wreq_tgt, nw.tag, nw.ctr, nw.tgt); end
        checks++; if (io_resp_valid !== lk_en) begin failures++;
            $display("FAIL upd_wr_resp_valid got=%0h exp=%0h", io_resp_valid, lk_en); end
        if (lk_en) begin
            le = (lk_set == set) ? nw : ref_tbl[lk_set];
            checks++; if (io_resp_bits_hit !== (le.tag == lk_tag) ||
                          io_resp_bits_ctr !== le.ctr || io_resp_bits_target !== le.tgt) begin
                failures++; $display("FAIL chk_lookup set=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                    lk_set, io_resp_bits_hit, io_resp_bits_ctr, io_resp_bits_target,
                    (le.tag == lk_tag), le.ctr, le.tgt); end
        end
        ref_tbl[set] = nw;
        tick();
    endtask

    task automatic test_train();
        for (int i = 0; i < 3; i++) do_update(7'd5, 9'h1A, 1'b1, 39'h100, 1'b0, 7'd0, 9'd0);
        checks++; if (ref_tbl[5].ctr !== 2'd3) begin failures++;
            $display("FAIL train_model_ctr got=%0h exp=3", ref_tbl[5].ctr); end
    endtask

    task automatic test_lookup();
        do_lookup(7'd5, 9'h1A);
        do_lookup(7'd5, 9'h1B);
        do_lookup(7'd6, 9'h1A);
    endtask

    task automatic test_not_taken();
        for (int i = 0; i < 4; i++) do_update(7'd5, 9'h1A, 1'b0, 39'h7F, 1'b0, 7'd0, 9'd0);
        do_lookup(7'd5, 9'h1A);
    endtask

    task automatic test_bypass();
        do_update(7'd5, 9'h1A, 1'b1, 39'h222, 1'b1, 7'd5, 9'h1A);
        do_update(7'd5, 9'h1C, 1'b0, 39'h333, 1'b1, 7'd5, 9'h1A);
        do_update(7'd5, 9'h1C, 1'b1, 39'h444, 1'b1, 7'd6, 9'h1C);
    endtask

    // Lookup valid held across an update to the same set, both accepted in IDLE.
    task automatic test_held_valid();
        ent_t old, nw;
        old = ref_tbl[9];
        nw  = model_next(old, 9'h0A5, 1'b1, 39'h55AA);
        io_req_valid = 1'b1; io_req_bits_setIdx = 7'd9; io_req_bits_tag = 9'h0A5;
        io_update_valid = 1'b1; io_update_bits_setIdx = 7'd9; io_update_bits_tag = 9'h0A5;
        io_update_bits_taken = 1'b1; io_update_bits_target = 39'h55AA;
        #1;
        checks++; if (io_sram_rreq_valid !== 1'b1 || io_req_ready !== 1'b1 ||
                      io_update_ready !== 1'b1) begin failures++;
            $display("FAIL held_idle got=%0h/%0h/%0h exp=1/1/1", io_sram_rreq_valid,
                     io_req_ready, io_update_ready); end
        tick();
        io_update_valid = 1'b0;
        #1;
        checks++; if (io_req_ready !== 1'b0 || io_resp_valid !== 1'b1 ||
                      io_resp_bits_hit !== (old.tag == 9'h0A5) || io_resp_bits_ctr !== old.ctr)
        begin failures++;
            $display("FAIL held_rd got=%0h/%0h/%0h/%0h exp=0/1/%0h/%0h", io_req_ready,
                     io_resp_valid, io_resp_bits_hit, io_resp_bits_ctr,
                     (old.tag == 9'h0A5), old.ctr); end
        tick(); #1;
        checks++; if (io_req_ready !== 1'b1 || io_resp_valid !== 1'b0 ||
                      io_sram_rreq_valid !== 1'b1) begin failures++;
            $display("FAIL held_chk got=%0h/%0h/%0h exp=1/0/1", io_req_ready,
                     io_resp_valid, io_sram_rreq_valid); end
        tick(); #1;
        checks++; if (io_req_ready !== 1'b0 || io_sram_wreq_valid !== 1'b1 ||
                      io_resp_valid !== 1'b1 || io_resp_bits_hit !== 1'b1 ||
                      io_resp_bits_ctr !== nw.ctr || io_resp_bits_target !== nw.tgt) begin
            failures++; $display("FAIL held_wr got=%0h/%0h/%0h/%0h/%0h/%0h exp=0/1/1/1/%0h/%0h",
                io_req_ready, io_sram_wreq_valid, io_resp_valid, io_resp_bits_hit,
                io_resp_bits_ctr, io_resp_bits_target, nw.ctr, nw.tgt); end
        ref_tbl[9] = nw;
        tick(); #1;
        checks++; if (io_req_ready !== 1'b1 || io_resp_valid !== 1'b0) begin failures++;
            $display("FAIL held_idle2 got=%0h/%0h exp=1/0", io_req_ready, io_resp_valid); end
        tick();
        io_req_valid = 1'b0;
        #1;
        checks++; if (io_resp_valid !== 1'b1 || io_resp_bits_ctr !== nw.ctr ||
                      io_resp_bits_target !== nw.tgt) begin failures++;
            $display("FAIL held_after_wr got=%0h/%0h/%0h exp=1/%0h/%0h", io_resp_valid,
                     io_resp_bits_ctr, io_resp_bits_target, nw.ctr, nw.tgt); end
        tick();
    endtask

    task automatic test_reset_mid();
        io_update_valid = 1'b1; io_update_bits_setIdx = 7'd5; io_update_bits_tag = 9'h77;
        io_update_bits_taken = 1'b1; io_update_bits_target = 39'h999;
        tick();
        io_update_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (io_sram_wreq_valid !== 1'b0) begin failures++;
            $display("FAIL rstmid_chk_wreq got=%0h exp=0", io_sram_wreq_valid); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (io_sram_wreq_valid !== 1'b0 || io_update_ready !== 1'b1 ||
                      io_resp_valid !== 1'b0) begin failures++;
            $display("FAIL rstmid_after got=%0h/%0h/%0h exp=0/1/0", io_sram_wreq_valid,
                     io_update_ready, io_resp_valid); end
        tick();
        io_req_valid = 1'b1; io_req_bits_setIdx = 7'd5; io_req_bits_tag = 9'h1C;
        tick();
        io_req_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (io_resp_valid !== 1'b0) begin failures++;
            $display("FAIL rst_after_lookup got=%0h exp=0", io_resp_valid); end
        tick();
        do_lookup(7'd5, 9'h77);
    endtask

    task automatic test_random();
        logic [8:0] pool [4];
        logic [6:0] s, ls;
        logic [8:0] t;
        int op;
        pool[0] = 9'h1A; pool[1] = 9'h1B; pool[2] = 9'h005; pool[3] = 9'h000;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            s  = 7'(20 + $urandom_range(0, 3));
            ls = 7'(20 + $urandom_range(0, 3));
            t  = pool[$urandom_range(0, 3)];
            if (op == 0) do_lookup(s, t);
            else do_update(s, t, 1'($urandom), 39'({$urandom, $urandom}), op == 2, ls,
                           pool[$urandom_range(0, 3)]);
        end
    endtask

    task automatic test_no_collision();
        checks++; if (collisions !== 0) begin failures++;
            $display("FAIL port_collision got=%0d exp=0", collisions); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = '0;
            ref_tbl[i] = '0;
        end
        #1;
        test_reset();
        test_train();
        test_lookup();
        test_not_taken();
        test_bypass();
        test_held_valid();
        test_reset_mid();
        test_random();
        test_no_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
